// File: rtl/i2c_codec_target.sv
`timescale 1ns/1ps
// i2c_codec_target: write-only I2C target standing in for an audio codec
// control port. Decodes START/STOP, matches DEV_ADDR, accepts 2-byte words
// {addr[6:0],data[8]},{data[7:0]} and stores them in a small register file.
// Optional glitch filter on SCL/SDA: `define I2C_CODEC_TARGET_GLITCH_FILTER_EN
// Ports:
//   i_clk, i_rst_n      system clock (>= 8x SCL), async active-low reset
//   i_sclk, i_sdat      sampled I2C lines
//   o_sda_oe            1 = pull SDA low (ACK)
//   o_wr_valid          one-cycle pulse per committed write
//   o_wr_addr/o_wr_data address/data of last commit
//   i_rd_addr/o_rd_data combinational register file read (0 if out of range)
//   o_busy              high from START until STOP
//   o_nack_cnt          saturating count of NACKed bytes
module i2c_codec_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned NUM_REGS  = 10,
  parameter logic [6:0]  RESET_REG = 7'h0F,
  parameter int unsigned FILT_LEN  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic [7:0] o_nack_cnt
);

  localparam int unsigned BCW  = 4;
  localparam int unsigned IDXW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE
  } state_t;

  // Two-flop synchronizers, reset to the idle (high) bus level
  logic [1:0] scl_sync_q, sda_sync_q;
  logic [1:0] sync_c, line_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_sclk};
      sda_sync_q <= {sda_sync_q[0], i_sdat};
    end
  end

  assign sync_c = {scl_sync_q[1], sda_sync_q[1]};

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
  localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [1:0]     filt_q;
  logic [FCW-1:0] fcnt_q [2];

  // Each line follows its input only after FILT_LEN consecutive new samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_c[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync_c[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  assign line_c = filt_q;
`else
  logic unused_filt_len;
  assign unused_filt_len = |32'(FILT_LEN);
  assign line_c = sync_c;
`endif

  // Previous-value register for edge / bus-condition detection
  logic scl_p_q, sda_p_q;
  logic scl_c, sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= line_c[1];
      sda_p_q <= line_c[0];
    end
  end

  assign scl_c      = line_c[1];
  assign sda_c      = line_c[0];
  assign scl_rise_c = scl_c & ~scl_p_q;
  assign scl_fall_c = ~scl_c & scl_p_q;
  assign start_c    = scl_c & scl_p_q & sda_p_q & ~sda_c;
  assign stop_c     = scl_c & scl_p_q & ~sda_p_q & sda_c;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d, byte1_q, byte1_d;
  logic           sda_oe_d, wr_valid_d, busy_d, third_q, third_d;
  logic [6:0]     wr_addr_d, reg_addr_c;
  logic [8:0]     wr_data_d;
  logic [7:0]     nack_d;
  logic           nack_inc_c, commit_c, addr_ok_c;

  assign reg_addr_c = byte1_q[7:1];
  assign addr_ok_c  = (32'(reg_addr_c) < NUM_REGS) || (reg_addr_c == RESET_REG);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      byte1_q    <= '0;
      third_q    <= 1'b0;
      o_sda_oe   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
      o_nack_cnt <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      byte1_q    <= byte1_d;
      third_q    <= third_d;
      o_sda_oe   <= sda_oe_d;
      o_wr_valid <= wr_valid_d;
      o_wr_addr  <= wr_addr_d;
      o_wr_data  <= wr_data_d;
      o_busy     <= busy_d;
      o_nack_cnt <= nack_d;
    end
  end

  // Next-state / output logic. bit_cnt counts sampled bits; 8 means the byte
  // is complete and the decision is taken on the following SCL fall.
  // In S_IGNORE bit_cnt runs 0..8 per 9-clock byte frame; third_q selects
  // whether ignored bytes count as NACKs (not after an address mismatch).
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    byte1_d    = byte1_q;
    third_d    = third_q;
    sda_oe_d   = o_sda_oe;
    wr_valid_d = 1'b0;
    wr_addr_d  = o_wr_addr;
    wr_data_d  = o_wr_data;
    nack_inc_c = 1'b0;
    commit_c   = 1'b0;
    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise_c && bit_cnt_q < BCW'(8)) begin
            shreg_d   = {shreg_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else if (scl_fall_c && bit_cnt_q == BCW'(8)) begin
            bit_cnt_d = '0;
            if (state_q == S_ADDR) begin
              if (shreg_q == {DEV_ADDR, 1'b0}) begin
                state_d  = S_ACK_ADDR;
                sda_oe_d = 1'b1;
              end else begin
                state_d    = S_IGNORE;
                bit_cnt_d  = BCW'(8);
                third_d    = 1'b0;
                nack_inc_c = 1'b1;
              end
            end else if (state_q == S_BYTE1) begin
              byte1_d  = shreg_q;
              state_d  = S_ACK1;
              sda_oe_d = 1'b1;
            end else if (addr_ok_c) begin
              state_d    = S_ACK2;
              sda_oe_d   = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = reg_addr_c;
              wr_data_d  = {byte1_q[0], shreg_q};
              commit_c   = 1'b1;
            end else begin
              state_d    = S_IGNORE;
              bit_cnt_d  = BCW'(8);
              third_d    = 1'b1;
              nack_inc_c = 1'b1;
            end
          end
        end
        S_ACK_ADDR, S_ACK1, S_ACK2: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            third_d   = 1'b1;
            state_d   = (state_q == S_ACK_ADDR) ? S_BYTE1 :
                        (state_q == S_ACK1)     ? S_BYTE2 : S_IGNORE;
          end
        end
        S_IGNORE: begin
          if (scl_rise_c) begin
            nack_inc_c = third_q && (bit_cnt_q == BCW'(7));
            bit_cnt_d  = (bit_cnt_q == BCW'(8)) ? '0 : bit_cnt_q + BCW'(1);
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != S_IDLE);
    nack_d = (nack_inc_c && o_nack_cnt != 8'hFF) ? o_nack_cnt + 8'd1 : o_nack_cnt;
  end

  // Register file; a write to RESET_REG clears every entry
  logic [8:0] regs_q [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (commit_c) begin
      if (reg_addr_c == RESET_REG) begin
        for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else if (32'(reg_addr_c) < NUM_REGS) begin
        regs_q[IDXW'(reg_addr_c)] <= {byte1_q[0], shreg_q};
      end
    end
  end

  assign o_rd_data = (32'(i_rd_addr) < NUM_REGS) ? regs_q[IDXW'(i_rd_addr)] : '0;

endmodule

// File: tb/tb_i2c_codec_target.sv
`timescale 1ns/1ps
// Testbench for i2c_codec_target: bit-banged I2C master, open-drain SDA,
// and a transaction-level reference model of ACKs, commits and registers.
module tb_i2c_codec_target;

  localparam int Q = 8;  // quarter SCL period in i_clk cycles

  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1;
  logic       sdat, sda_oe, wr_valid, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic [3:0] rd_addr = '0;
  logic [7:0] nack_cnt;

  always #5 clk = ~clk;
  assign sdat = m_sda & ~sda_oe;

  i2c_codec_target dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(scl), .i_sdat(sdat),
    .o_sda_oe(sda_oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_busy(busy), .o_nack_cnt(nack_cnt)
  );

  int total = 0, bad = 0;

  // Observation of write pulses and SDA drive
  int         wr_cnt = 0, oe_cycles = 0, coinc_bad = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
      if (!sda_oe) coinc_bad++;
    end
    if (sda_oe) oe_cycles++;
  end

  // Reference model state
  logic [8:0] mregs [16];
  int         mnack = 0, mwr = 0;
  logic [6:0] maddr = '0;
  logic [8:0] mdata = '0;

  // Current transaction
  logic [7:0] tx_b [8];
  logic       obs_ack [8];
  int         tx_n, tx_part;
  logic       tx_stop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic ack_slot(output logic a);
    m_sda = 1'b1; wq();
    scl = 1'b1; wq();
    a = sda_oe; wq();
    scl = 1'b0; wq();
  endtask

  task automatic start_cond();
    m_sda = 1'b1; wq();
    scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; wq();
    scl = 1'b1; wq();
    m_sda = 1'b1; wq(); wq();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
  endtask

  task automatic do_txn();
    start_cond();
    for (int i = 0; i < tx_n; i++) begin
      send_byte(tx_b[i]);
      ack_slot(obs_ack[i]);
    end
    for (int k = 7; k > 7 - tx_part; k--) send_bit(tx_b[tx_n][k]);
    if (tx_stop) stop_cond();
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s_rd%0d", tag, a), 32'(rd_data), (a < 10) ? 32'(mregs[a]) : 32'd0);
    end
  endtask

  // Expected behaviour of a whole transaction from the protocol rules
  task automatic model_check(input string tag);
    logic       addr_ok, exp;
    logic [6:0] ra;
    addr_ok = (tx_b[0] == 8'h34);
    ra = tx_b[1][7:1];
    for (int i = 0; i < tx_n; i++) begin
      if (i < 2)       exp = addr_ok;
      else if (i == 2) exp = addr_ok && (ra < 7'd10 || ra == 7'h0F);
      else             exp = 1'b0;
      chk($sformatf("%s_ack%0d", tag, i), 32'(obs_ack[i]), 32'(exp));
      if (!exp && (i == 0 || addr_ok)) mnack = (mnack < 255) ? mnack + 1 : 255;
      if (i == 2 && exp) begin
        mwr++;
        maddr = ra;
        mdata = {tx_b[1][0], tx_b[2]};
        if (ra == 7'h0F) for (int r = 0; r < 16; r++) mregs[r] = '0;
        else mregs[ra[3:0]] = mdata;
      end
    end
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(mwr));
    chk({tag, "_wraddr"}, 32'(last_addr), 32'(maddr));
    chk({tag, "_wrdata"}, 32'(last_data), 32'(mdata));
    chk({tag, "_nack"}, 32'(nack_cnt), 32'(mnack));
    chk({tag, "_busy"}, 32'(busy), 32'(!tx_stop));
    check_regs(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   oe_before;
    for (int r = 0; r < 16; r++) mregs[r] = '0;

    // Reset then idle bus
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_oe", 32'(sda_oe), 0);
    chk("idle_wrv", 32'(wr_valid), 0);
    chk("idle_wraddr", 32'(wr_addr), 0);
    chk("idle_wrdata", 32'(wr_data), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_nack", 32'(nack_cnt), 0);
    check_regs("idle");

    // Basic write: reg4 = 0x015
    tx_b[0] = 8'h34; tx_b[1] = 8'h08; tx_b[2] = 8'h15;
    tx_n = 3; tx_part = 0; tx_stop = 1'b1;
    do_txn(); model_check("w4");
    chk("w4_addr_const", 32'(wr_addr), 32'd4);
    chk("w4_data_const", 32'(wr_data), 32'h015);

    // Wrong device address: never drive SDA
    oe_before = oe_cycles;
    tx_b[0] = 8'h36; tx_b[1] = 8'h10; tx_b[2] = 8'h19;
    do_txn(); model_check("wrongdev");
    chk("wrongdev_nodrive", 32'(oe_cycles - oe_before), 0);
    chk("wrongdev_nack_const", 32'(nack_cnt), 32'd1);

    // reg8 = 0x019, repeated START, then write to RESET_REG
    tx_b[0] = 8'h34; tx_b[1] = 8'h10; tx_b[2] = 8'h19; tx_stop = 1'b0;
    do_txn(); model_check("w8");
    tx_b[0] = 8'h34; tx_b[1] = 8'h1E; tx_b[2] = 8'h00; tx_stop = 1'b1;
    do_txn(); model_check("clr");
    chk("clr_addr_const", 32'(wr_addr), 32'h0F);

    // Abort byte2 after 4 bits with STOP
    tx_b[0] = 8'h34; tx_b[1] = 8'h12; tx_b[2] = 8'hA5;
    tx_n = 2; tx_part = 4; tx_stop = 1'b1;
    do_txn(); model_check("partial");

    // Out-of-range address 10: byte2 NACKed
    tx_b[0] = 8'h34; tx_b[1] = 8'h14; tx_b[2] = 8'h00;
    tx_n = 3; tx_part = 0; tx_stop = 1'b1;
    do_txn(); model_check("oor");

    // Async reset while ACK is driven, then bus ignored until next START
    start_cond();
    send_byte(8'h34);
    chk("rst_oe_pre", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_oe_drop", 32'(sda_oe), 0);
    for (int r = 0; r < 16; r++) mregs[r] = '0;
    mnack = 0; maddr = '0; mdata = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ack_slot(a);
    chk("rst_no_ack", 32'(a), 0);
    send_byte(8'h10);
    ack_slot(a);
    chk("rst_ignored", 32'(a), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nack", 32'(nack_cnt), 0);
    chk("rst_wraddr", 32'(wr_addr), 0);
    chk("rst_wrdata", 32'(wr_data), 0);
    last_addr = '0; last_data = '0;
    tx_b[0] = 8'h34; tx_b[1] = 8'h0B; tx_b[2] = 8'h5A;
    tx_n = 3; tx_part = 0; tx_stop = 1'b1;
    do_txn(); model_check("post_rst");

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      logic [6:0] ra;
      logic [8:0] d;
      tx_b[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
      ra = 7'($urandom_range(0, 17));
      if ($urandom_range(0, 7) == 0) ra = 7'h0F;
      d = 9'($urandom);
      tx_b[1] = {ra, d[8]};
      tx_b[2] = d[7:0];
      tx_b[3] = 8'($urandom);
      tx_b[4] = 8'($urandom);
      tx_n = 3 + (($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
      tx_part = 0;
      if ($urandom_range(0, 5) == 0) begin
        tx_n = 2;
        tx_part = int'($urandom_range(1, 7));
      end
      tx_stop = (tx_part != 0) || ($urandom_range(0, 3) != 0);
      do_txn();
      model_check($sformatf("rnd%0d", t));
    end
    if (!tx_stop) stop_cond();

    chk("wr_with_oe", 32'(coinc_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
